turn_ctrl: RTL and testbench
============================

TURN_CTRL -- requirements
Module: turn_ctrl

Interface
REQ-001 SHALL have parameter DEB_CYC, default 250000, debounce stability window in clk cycles (minimum 2; benches use 4).
REQ-002 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port N  input  4  player count, valid values 2..4.
REQ-005 SHALL have port start  input  1  level; begins a game when sampled high in IDLE.
REQ-006 SHALL have port stop  input  1  level; ends the game, return to IDLE.
REQ-007 SHALL have port step_btn  input  1  raw asynchronous push-button level, 1 = pressed.
REQ-008 SHALL have port match  input  1  card-match result for the current step, 1 = matched.
REQ-009 SHALL have ports p_da1..p_da4  output  1 each  move-enable for players 1..4, one-hot or all zero.
REQ-010 SHALL have port step_pulse  output  1  single-cycle move strobe feeding the player position counters.
REQ-011 SHALL have port cur_player  output  2  index of the active player, 0 = player 1.
REQ-012 SHALL have port turn_cnt  output  8  count of turn hand-overs, saturating.

Function
REQ-013 SHALL synchronise step_btn through two flip-flops (sync1, sync2) before any other use.
REQ-014 SHALL debounce sync2 into btn_db using a counter:
- sync2 != btn_db: counter increments; on the edge where counter == DEB_CYC-1, btn_db takes sync2 and the counter clears.
- sync2 == btn_db: counter clears.
REQ-015 SHALL detect a press as btn_db==1 while its one-cycle-delayed copy == 0.
REQ-016 SHALL implement the FSM states IDLE, TURN, MOVE and PASS.
REQ-017 IDLE: all p_da low; if start==1, latch N into n_lat, set cur_player=0, go to TURN.
REQ-018 n_lat SHALL be 2 when N is outside 2..4; changes to N during a game SHALL be ignored.
REQ-019 TURN: p_da(cur_player+1)=1, all others 0; on a detected press go to MOVE.
REQ-020 MOVE lasts exactly one cycle with step_pulse=1 and p_da held; match is sampled on that cycle.
- match=1: go to TURN (same player continues).
- match=0: go to PASS.
REQ-021 PASS lasts exactly one cycle with step_pulse=0. On exit:
- cur_player = (cur_player+1) mod n_lat.
- turn_cnt increments, holding at 255.
- next state is TURN.
REQ-022 Presses detected while in MOVE or PASS SHALL be discarded (not queued).
REQ-023 stop==1 in any non-IDLE state SHALL force IDLE on the next edge, overriding every other transition.
- In that cycle step_pulse SHALL be 0 even if a press was detected.
- turn_cnt and cur_player hold their values until the next start.
REQ-024 turn_cnt SHALL clear to 0 on the IDLE->TURN transition.
REQ-025 step_pulse SHALL never be high for two consecutive cycles.
REQ-026 step_pulse latency SHALL be exactly DEB_CYC+3 rising edges after the first edge that samples step_btn=1, given a stable press, state TURN and stop=0.
REQ-027 start held high across a game SHALL have no effect outside IDLE.

Reset
REQ-028 While rst==0, all registers SHALL clear asynchronously:
- state=IDLE, cur_player=0, n_lat=2, turn_cnt=0, step_pulse=0, p_da1..4=0.
- sync1=sync2=0, btn_db=0, its delayed copy=0, debounce counter=0.
REQ-029 Reset asserted mid-MOVE SHALL drop step_pulse immediately, without waiting for a clock edge.
REQ-030 After rst deasserts, the block SHALL remain in IDLE until start is sampled high.

Verification (DEB_CYC=4)
REQ-031 Start with N=3, press step_btn 10 cycles with match=0 -> step_pulse high for one cycle 7 edges after press; cur_player goes 0->1; turn_cnt=1; p_da2=1.
REQ-032 N=3, match=0 on every press, 4 presses -> cur_player sequence 1,2,0,1; turn_cnt=4.
REQ-033 match=1 on the press -> step_pulse pulses once; cur_player unchanged; p_da1 stays 1; turn_cnt=0.
REQ-034 Button bounce (1-cycle glitches shorter than 4 cycles) -> no step_pulse; one clean 10-cycle press -> exactly one step_pulse.
REQ-035 N=7 at start -> behaves as 2 players (cur_player alternates 0,1); changing N to 4 mid-game has no effect.
REQ-036 stop asserted on the same edge a press is detected -> IDLE next cycle, step_pulse stays 0, all p_da=0; rst low during MOVE -> step_pulse=0 with no clock edge.

Source files
------------

// File: rtl/turn_ctrl.sv
`default_nettype none
// turn_ctrl: debounced step-button turn sequencer for a 2..4 player board game.
// Rev 1.0 -- initial release.
module turn_ctrl #(
  parameter int DEB_CYC = 250000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] N,
  input  logic       start,
  input  logic       stop,
  input  logic       step_btn,
  input  logic       match,
  output logic       p_da1,
  output logic       p_da2,
  output logic       p_da3,
  output logic       p_da4,
  output logic       step_pulse,
  output logic [1:0] cur_player,
  output logic [7:0] turn_cnt
);

  localparam int            CW      = (DEB_CYC > 2) ? $clog2(DEB_CYC) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_TURN = 2'd1,
    S_MOVE = 2'd2,
    S_PASS = 2'd3
  } state_t;

  logic          sync1_q, sync2_q;
  logic          btn_db_q, btn_dly_q;
  logic [CW-1:0] deb_cnt_q;
  logic          press;

  state_t        state_q, state_d;
  logic [2:0]    n_lat_q, n_lat_d;
  logic [1:0]    cur_q, cur_d;
  logic [7:0]    tcnt_q, tcnt_d;
  logic [2:0]    cur_inc;
  logic [3:0]    pda;

  // Button conditioning: two-flop synchroniser, then a stability counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      btn_db_q  <= 1'b0;
      btn_dly_q <= 1'b0;
      deb_cnt_q <= '0;
    end else begin
      sync1_q   <= step_btn;
      sync2_q   <= sync1_q;
      btn_dly_q <= btn_db_q;
      if (sync2_q != btn_db_q) begin
        if (deb_cnt_q == CNT_MAX) begin
          btn_db_q  <= sync2_q;
          deb_cnt_q <= '0;
        end else begin
          deb_cnt_q <= deb_cnt_q + 1'b1;
        end
      end else begin
        deb_cnt_q <= '0;
      end
    end
  end

  assign press   = btn_db_q & ~btn_dly_q;
  assign cur_inc = {1'b0, cur_q} + 3'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      n_lat_q <= 3'd2;
      cur_q   <= 2'd0;
      tcnt_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      n_lat_q <= n_lat_d;
      cur_q   <= cur_d;
      tcnt_q  <= tcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    n_lat_d = n_lat_q;
    cur_d   = cur_q;
    tcnt_d  = tcnt_q;
    // stop beats every other transition and freezes player/turn bookkeeping.
    if ((state_q != S_IDLE) && stop) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d = S_TURN;
            n_lat_d = ((N >= 4'd2) && (N <= 4'd4)) ? N[2:0] : 3'd2;
            cur_d   = 2'd0;
            tcnt_d  = 8'd0;
          end
        end
        S_TURN: begin
          if (press) begin
            state_d = S_MOVE;
          end
        end
        S_MOVE: begin
          state_d = match ? S_TURN : S_PASS;
        end
        S_PASS: begin
          state_d = S_TURN;
          cur_d   = (cur_inc >= n_lat_q) ? 2'd0 : cur_inc[1:0];
          tcnt_d  = (tcnt_q == 8'hFF) ? tcnt_q : tcnt_q + 8'd1;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // Decoded from state so an asynchronous reset drops the strobe at once.
  always_comb begin
    pda = 4'b0000;
    if (state_q != S_IDLE) begin
      pda = 4'b0001 << cur_q;
    end
  end

  assign step_pulse = (state_q == S_MOVE) && !stop;
  assign p_da1      = pda[0];
  assign p_da2      = pda[1];
  assign p_da3      = pda[2];
  assign p_da4      = pda[3];
  assign cur_player = cur_q;
  assign turn_cnt   = tcnt_q;

endmodule
`default_nettype wire

// File: tb/tb_turn_ctrl.sv
`default_nettype none
// tb_turn_ctrl: table-driven bench for turn_ctrl with DEB_CYC=4.
module tb_turn_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] N = 4'd2;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       step_btn = 1'b0;
  logic       match = 1'b0;
  logic       p_da1, p_da2, p_da3, p_da4, step_pulse;
  logic [1:0] cur_player;
  logic [7:0] turn_cnt;

  int   checks = 0;
  int   errors = 0;
  logic prev_pulse = 1'b0;

  typedef struct {
    logic       new_game;
    logic [3:0] n;
    logic       m;
    logic [1:0] cur;
    logic [7:0] cnt;
    logic [3:0] pda;
  } vec_t;

  vec_t vecs[16];

  turn_ctrl #(.DEB_CYC(4)) dut (
    .clk(clk), .rst(rst), .N(N), .start(start), .stop(stop),
    .step_btn(step_btn), .match(match),
    .p_da1(p_da1), .p_da2(p_da2), .p_da3(p_da3), .p_da4(p_da4),
    .step_pulse(step_pulse), .cur_player(cur_player), .turn_cnt(turn_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (step_pulse) begin
      checks++;
      if (prev_pulse) begin
        errors++;
        $display("FAIL pulse_width: step_pulse high on two consecutive cycles at %0t", $time);
      end
    end
    prev_pulse = step_pulse;
  end

  function automatic int pda_now();
    return int'({p_da4, p_da3, p_da2, p_da1});
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic new_game(input logic [3:0] n);
    start = 1'b0;
    stop  = 1'b1;
    @(negedge clk);
    stop  = 1'b0;
    N     = n;
    start = 1'b1;
    @(negedge clk);
    chk("start_cur", int'(cur_player), 0);
    chk("start_cnt", int'(turn_cnt), 0);
    chk("start_pda", pda_now(), 1);
  endtask

  task automatic press(input int hold, input logic m, output int pulses, output int first_at);
    pulses   = 0;
    first_at = -1;
    match    = m;
    step_btn = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (step_pulse) begin
        pulses++;
        if (first_at < 0) first_at = k;
      end
      if (k == hold) step_btn = 1'b0;
    end
  endtask

  initial begin
    int pulses, first_at;

    vecs[0]  = '{1'b1, 4'd3, 1'b0, 2'd1, 8'd1, 4'b0010};
    vecs[1]  = '{1'b0, 4'd3, 1'b0, 2'd2, 8'd2, 4'b0100};
    vecs[2]  = '{1'b0, 4'd3, 1'b0, 2'd0, 8'd3, 4'b0001};
    vecs[3]  = '{1'b0, 4'd3, 1'b0, 2'd1, 8'd4, 4'b0010};
    vecs[4]  = '{1'b0, 4'd3, 1'b1, 2'd1, 8'd4, 4'b0010};
    vecs[5]  = '{1'b1, 4'd3, 1'b1, 2'd0, 8'd0, 4'b0001};
    vecs[6]  = '{1'b1, 4'd7, 1'b0, 2'd1, 8'd1, 4'b0010};
    vecs[7]  = '{1'b0, 4'd4, 1'b0, 2'd0, 8'd2, 4'b0001};
    vecs[8]  = '{1'b0, 4'd4, 1'b0, 2'd1, 8'd3, 4'b0010};
    vecs[9]  = '{1'b0, 4'd4, 1'b0, 2'd0, 8'd4, 4'b0001};
    vecs[10] = '{1'b1, 4'd4, 1'b0, 2'd1, 8'd1, 4'b0010};
    vecs[11] = '{1'b0, 4'd4, 1'b0, 2'd2, 8'd2, 4'b0100};
    vecs[12] = '{1'b0, 4'd4, 1'b0, 2'd3, 8'd3, 4'b1000};
    vecs[13] = '{1'b0, 4'd4, 1'b0, 2'd0, 8'd4, 4'b0001};
    vecs[14] = '{1'b1, 4'd2, 1'b0, 2'd1, 8'd1, 4'b0010};
    vecs[15] = '{1'b0, 4'd2, 1'b0, 2'd0, 8'd2, 4'b0001};

    // Reset and post-reset idle
    repeat (3) @(negedge clk);
    chk("rst_cur", int'(cur_player), 0);
    chk("rst_cnt", int'(turn_cnt), 0);
    chk("rst_pda", pda_now(), 0);
    chk("rst_pulse", int'(step_pulse), 0);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle_pda", pda_now(), 0);

    // Table: start stays high through each game
    for (int i = 0; i < 16; i++) begin
      if (vecs[i].new_game) new_game(vecs[i].n);
      N = vecs[i].n;
      press(10, vecs[i].m, pulses, first_at);
      chk($sformatf("v%0d_pulses", i), pulses, 1);
      chk($sformatf("v%0d_latency", i), first_at, 7);
      chk($sformatf("v%0d_cur", i), int'(cur_player), int'(vecs[i].cur));
      chk($sformatf("v%0d_cnt", i), int'(turn_cnt), int'(vecs[i].cnt));
      chk($sformatf("v%0d_pda", i), pda_now(), int'(vecs[i].pda));
    end

    // Bounce: short glitches must never produce a step
    new_game(4'd2);
    start = 1'b0;
    pulses = 0;
    for (int g = 0; g < 5; g++) begin
      step_btn = 1'b1;
      @(negedge clk);
      if (step_pulse) pulses++;
      step_btn = 1'b0;
      @(negedge clk);
      if (step_pulse) pulses++;
    end
    step_btn = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (step_pulse) pulses++;
    end
    step_btn = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (step_pulse) pulses++;
    end
    chk("bounce_pulses", pulses, 0);
    chk("bounce_cur", int'(cur_player), 0);
    press(10, 1'b0, pulses, first_at);
    chk("clean_pulses", pulses, 1);
    chk("clean_cur", int'(cur_player), 1);
    chk("clean_cnt", int'(turn_cnt), 1);

    // stop on the cycle a press is detected
    match    = 1'b0;
    step_btn = 1'b1;
    repeat (6) @(negedge clk);
    chk("stop_pre_pulse", int'(step_pulse), 0);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("stop_pulse", int'(step_pulse), 0);
    chk("stop_pda", pda_now(), 0);
    chk("stop_cur", int'(cur_player), 1);
    chk("stop_cnt", int'(turn_cnt), 1);
    step_btn = 1'b0;
    pulses = 0;
    repeat (20) begin
      @(negedge clk);
      if (step_pulse) pulses++;
    end
    chk("stop_idle_pulses", pulses, 0);
    chk("stop_idle_pda", pda_now(), 0);
    chk("stop_hold_cnt", int'(turn_cnt), 1);

    // Asynchronous reset in the middle of MOVE
    new_game(4'd3);
    start    = 1'b0;
    step_btn = 1'b1;
    repeat (7) @(negedge clk);
    chk("move_pulse", int'(step_pulse), 1);
    #1 rst = 1'b0;
    #1;
    chk("arst_pulse", int'(step_pulse), 0);
    chk("arst_pda", pda_now(), 0);
    step_btn = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("arst_idle_pda", pda_now(), 0);
    chk("arst_idle_cnt", int'(turn_cnt), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
